// File: rtl/alu_thread_arbiter_if.sv
// Bundle between the thread request ports, the shared ALU and the response consumer.
interface alu_thread_arbiter_if #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = $clog2(NUM_THREADS)
);
  // Per-thread request side, operands packed 32/32/5/4 bits per thread
  logic [NUM_THREADS-1:0]    req_valid;
  logic [NUM_THREADS-1:0]    req_ready;
  logic [NUM_THREADS*32-1:0] req_a;
  logic [NUM_THREADS*32-1:0] req_b;
  logic [NUM_THREADS*5-1:0]  req_shamt;
  logic [NUM_THREADS*4-1:0]  req_ctrl;

  // Issue stage to the combinational ALU and its result back
  logic [31:0]               alu_a;
  logic [31:0]               alu_b;
  logic [4:0]                alu_shamt;
  logic [3:0]                alu_ctrl;
  logic [31:0]               alu_result;
  logic                      alu_zero;

  // Response register towards the consumer
  logic                      resp_valid;
  logic                      resp_ready;
  logic [TID_W-1:0]          resp_tid;
  logic [31:0]               resp_result;
  logic                      resp_zero;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_shamt, req_ctrl,
    output req_ready,
    output alu_a, alu_b, alu_shamt, alu_ctrl,
    input  alu_result, alu_zero,
    output resp_valid, resp_tid, resp_result, resp_zero,
    input  resp_ready
  );

  // Threads, ALU and consumer side
  modport master (
    output req_valid, req_a, req_b, req_shamt, req_ctrl,
    input  req_ready,
    input  alu_a, alu_b, alu_shamt, alu_ctrl,
    output alu_result, alu_zero,
    input  resp_valid, resp_tid, resp_result, resp_zero,
    output resp_ready
  );
endinterface

// File: rtl/alu_thread_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among hardware threads.
// Two-stage pipe: issue register (drives the ALU) then response register (result + TID).
module alu_thread_arbiter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_thread_arbiter_if.slave  bus
);

  logic [31:0] req_a_arr     [NUM_THREADS];
  logic [31:0] req_b_arr     [NUM_THREADS];
  logic [4:0]  req_shamt_arr [NUM_THREADS];
  logic [3:0]  req_ctrl_arr  [NUM_THREADS];

  for (genvar g = 0; g < int'(NUM_THREADS); g++) begin : g_unpack
    assign req_a_arr[g]     = bus.req_a[32*g +: 32];
    assign req_b_arr[g]     = bus.req_b[32*g +: 32];
    assign req_shamt_arr[g] = bus.req_shamt[5*g +: 5];
    assign req_ctrl_arr[g]  = bus.req_ctrl[4*g +: 4];
  end

  logic             s1_v_q, s1_v_d;
  logic [TID_W-1:0] s1_tid_q, s1_tid_d;
  logic [TID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [4:0]       alu_shamt_q, alu_shamt_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             resp_valid_q, resp_valid_d;
  logic [TID_W-1:0] resp_tid_q, resp_tid_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;

  logic             s2_en, s1_en;
  logic             grant_any, handshake;
  logic [TID_W-1:0] win;
  logic [TID_W-1:0] scan_idx;

  assign s2_en = !resp_valid_q || bus.resp_ready;
  assign s1_en = !s1_v_q || s2_en;

  // Round-robin scan starting at rr_ptr; first requester wins
  always_comb begin
    grant_any = 1'b0;
    win       = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NUM_THREADS); k++) begin
      scan_idx = TID_W'((int'(rr_ptr_q) + k) % int'(NUM_THREADS));
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        win       = scan_idx;
      end
    end
  end

  // Grant only when the issue stage can take it; rst_n gate keeps ready low in reset
  assign handshake = grant_any && s1_en && rst_n;

  // One-hot accept to the winning thread
  always_comb begin
    bus.req_ready = '0;
    if (handshake) bus.req_ready[win] = 1'b1;
  end

  // Next state of issue and response stages
  always_comb begin
    s1_v_d        = s1_v_q;
    s1_tid_d      = s1_tid_q;
    rr_ptr_d      = rr_ptr_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_shamt_d   = alu_shamt_q;
    alu_ctrl_d    = alu_ctrl_q;
    resp_valid_d  = resp_valid_q;
    resp_tid_d    = resp_tid_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;

    if (s2_en) begin
      resp_valid_d = s1_v_q;
      if (s1_v_q) begin
        resp_result_d = bus.alu_result;
        resp_zero_d   = bus.alu_zero;
        resp_tid_d    = s1_tid_q;
      end
    end

    // Operands are left as-is on an empty issue slot; only s1_v marks them stale
    if (s1_en) begin
      s1_v_d = handshake;
      if (handshake) begin
        alu_a_d     = req_a_arr[win];
        alu_b_d     = req_b_arr[win];
        alu_shamt_d = req_shamt_arr[win];
        alu_ctrl_d  = req_ctrl_arr[win];
        s1_tid_d    = win;
        rr_ptr_d    = (win == TID_W'(NUM_THREADS - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously (in-flight ops are dropped)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q        <= 1'b0;
      s1_tid_q      <= '0;
      rr_ptr_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_shamt_q   <= '0;
      alu_ctrl_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_tid_q    <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      s1_v_q        <= s1_v_d;
      s1_tid_q      <= s1_tid_d;
      rr_ptr_q      <= rr_ptr_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      resp_valid_q  <= resp_valid_d;
      resp_tid_q    <= resp_tid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_shamt   = alu_shamt_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_tid    = resp_tid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_alu_thread_arbiter.sv
// Bench for alu_thread_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin choice, two-slot pipe, in-order responses).
module tb_alu_thread_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_thread_arbiter_if #(.NUM_THREADS(N)) bus ();

  alu_thread_arbiter #(.NUM_THREADS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference ALU: AND OR ADD SLL SRL SRA SUB SLT NOR, anything else yields 0
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return b << sh;
      4'b0100: return b >> sh;
      4'b0101: return $unsigned($signed(b) >>> sh);
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt);
    bus.alu_zero   = (alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shamt) == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_shamt = '0;
    bus.req_ctrl  = '0;
  endtask

  task automatic set_req(input int t, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    bus.req_valid[t]        = 1'b1;
    bus.req_a[32*t +: 32]   = a;
    bus.req_b[32*t +: 32]   = b;
    bus.req_shamt[5*t +: 5] = sh;
    bus.req_ctrl[4*t +: 4]  = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    bus.resp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < N; t++) set_req(t, 4'b0010, 32'(t + 1), 32'(t + 10), 5'd0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero} !== '0) begin
      errors++; $display("FAIL reset_resp: got v=%b tid=%0d res=%h z=%b want all 0",
                         bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_alu: got a=%h b=%h sh=%0d c=%b want all 0",
                         bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_ctrl);
    end
    tick();
    rst_n = 1'b1;
    bus.resp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_start: got %b want 0001", bus.req_ready);
    end
    tick();
    tick();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL pre_reset_full: got v=%b rdy=%b want v=1 rdy=0000",
                         bus.resp_valid, bus.req_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_tid !== 2'd0) begin
      errors++; $display("FAIL midreset_resp: got v=%b tid=%0d want v=0 tid=0",
                         bus.resp_valid, bus.resp_tid);
    end
    tick();
    rst_n = 1'b1;
    clear_reqs();
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        errors++; $display("FAIL no_stale_resp: cycle %0d got v=%b want 0", c, bus.resp_valid);
      end
    end
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_after_reset: got %b want 0001", bus.req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    bus.resp_ready = 1'b1;
    set_req(2, 4'b0010, 32'd5, 32'd7, 5'd0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b want 0100", bus.req_ready);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got v=%b want 0", bus.resp_valid);
    end
    tick();
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero} !==
        {1'b1, 2'd2, 32'd12, 1'b0}) begin
      errors++; $display("FAIL single_resp: got v=%b tid=%0d res=%0d z=%b want 1 2 12 0",
                         bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 2};
    apply_reset();
    bus.resp_ready = 1'b1;
    for (int t = 0; t < N; t++) set_req(t, 4'b0001, 32'(t), 32'(t << 4), 5'd0);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.req_valid[1] = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << exp_seq[c])) begin
        errors++; $display("FAIL rr_grant: step %0d got %b want T%0d", c, bus.req_ready,
                           exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(0, 4'b0010, 32'd100, 32'd1, 5'd0);
    set_req(1, 4'b0010, 32'd200, 32'd2, 5'd0);
    set_req(3, 4'b0010, 32'd300, 32'd3, 5'd0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_grant0: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant1: got %b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b1 || bus.resp_tid !== 2'd0) begin
        errors++; $display("FAIL bp_stall: cycle %0d got rdy=%b v=%b tid=%0d want 0000 1 0",
                           c, bus.req_ready, bus.resp_valid, bus.resp_tid);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.resp_result !== 32'd101) begin
      errors++; $display("FAIL bp_release: got rdy=%b res=%0d want 1000 101",
                         bus.req_ready, bus.resp_result);
    end
    tick();
    bus.req_valid[3] = 1'b0;
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result} !== {1'b1, 2'd1, 32'd202}) begin
      errors++; $display("FAIL bp_order1: got v=%b tid=%0d res=%0d want 1 1 202",
                         bus.resp_valid, bus.resp_tid, bus.resp_result);
    end
    tick();
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result} !== {1'b1, 2'd3, 32'd303}) begin
      errors++; $display("FAIL bp_order3: got v=%b tid=%0d res=%0d want 1 3 303",
                         bus.resp_valid, bus.resp_tid, bus.resp_result);
    end
  endtask

  task automatic test_zero_illegal();
    apply_reset();
    bus.resp_ready = 1'b1;
    set_req(1, 4'b0110, 32'd9, 32'd9, 5'd0);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(3, 4'b1111, 32'd123, 32'd456, 5'd3);
    tick();
    bus.req_valid[3] = 1'b0;
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero} !==
        {1'b1, 2'd1, 32'd0, 1'b1}) begin
      errors++; $display("FAIL zero_sub: got v=%b tid=%0d res=%h z=%b want 1 1 0 1",
                         bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero);
    end
    tick();
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero} !==
        {1'b1, 2'd3, 32'd0, 1'b1}) begin
      errors++; $display("FAIL illegal_ctrl: got v=%b tid=%0d res=%h z=%b want 1 3 0 1",
                         bus.resp_valid, bus.resp_tid, bus.resp_result, bus.resp_zero);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.resp_ready = 1'b1;
    set_req(1, 4'b0011, 32'd0, 32'd1, 5'd31);
    set_req(3, 4'b0101, 32'd0, 32'h8000_0000, 5'd4);
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    bus.req_valid[3] = 1'b0;
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result} !== {1'b1, 2'd1, 32'h8000_0000}) begin
      errors++; $display("FAIL b2b_sll: got v=%b tid=%0d res=%h want 1 1 80000000",
                         bus.resp_valid, bus.resp_tid, bus.resp_result);
    end
    tick();
    #1;
    checks++;
    if ({bus.resp_valid, bus.resp_tid, bus.resp_result} !== {1'b1, 2'd3, 32'hF800_0000}) begin
      errors++; $display("FAIL b2b_sra: got v=%b tid=%0d res=%h want 1 3 f8000000",
                         bus.resp_valid, bus.resp_tid, bus.resp_result);
    end
  endtask

  function automatic logic [3:0] pick_ctrl();
    case ($urandom_range(0, 9))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0011;
      4: return 4'b0100;
      5: return 4'b0101;
      6: return 4'b0110;
      7: return 4'b0111;
      8: return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic test_random();
    // Model: next-to-serve pointer plus two optional in-flight ops (issue, response)
    int          m_rr = 0;
    bit          m_s1v = 0, m_rv = 0;
    int          m_s1tid = 0, m_rtid = 0;
    logic [31:0] m_s1res = '0, m_rres = '0;
    bit          granted = 0;
    int          gwin = 0;
    bit          any, s1_en, s2_en;
    int          w, c;
    logic [3:0]  exp_ready;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      for (int t = 0; t < N; t++) begin
        if (granted && t == gwin) bus.req_valid[t] = 1'b0;
        else if (bus.req_valid[t] && $urandom_range(0, 7) == 0) bus.req_valid[t] = 1'b0;
        else if (!bus.req_valid[t] && $urandom_range(0, 1) == 0)
          set_req(t, pick_ctrl(), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  5'($urandom_range(0, 31)));
      end
      bus.resp_ready = ((i % 50) < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      s2_en = !m_rv || bus.resp_ready;
      s1_en = !m_s1v || s2_en;
      any = 0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!any && bus.req_valid[c]) begin
          any = 1;
          w = c;
        end
      end
      exp_ready = (s1_en && any) ? 4'(1 << w) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", i, bus.req_ready,
                           exp_ready);
      end
      checks++;
      if (bus.resp_valid !== m_rv) begin
        errors++; $display("FAIL rand_resp_valid: cycle %0d got %b want %b", i,
                           bus.resp_valid, m_rv);
      end
      if (m_rv) begin
        checks++;
        if (bus.resp_tid !== 2'(m_rtid) || bus.resp_result !== m_rres ||
            bus.resp_zero !== (m_rres == 32'd0)) begin
          errors++; $display("FAIL rand_resp: cycle %0d got tid=%0d res=%h z=%b want %0d %h %b",
                             i, bus.resp_tid, bus.resp_result, bus.resp_zero, m_rtid, m_rres,
                             (m_rres == 32'd0));
        end
      end
      if (s2_en) begin
        m_rv = m_s1v;
        if (m_s1v) begin
          m_rtid = m_s1tid;
          m_rres = m_s1res;
        end
      end
      if (s1_en) begin
        m_s1v = any;
        if (any) begin
          m_s1tid = w;
          m_s1res = alu_f(bus.req_ctrl[4*w +: 4], bus.req_a[32*w +: 32],
                          bus.req_b[32*w +: 32], bus.req_shamt[5*w +: 5]);
          m_rr = (w + 1) % N;
        end
      end
      granted = s1_en && any;
      gwin = w;
      tick();
    end
  endtask

  initial begin
    clear_reqs();
    bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_illegal();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
